// File: rtl/clock_run_controller.sv
// Run/halt/single-step controller that drives the clock generator's enable.
// Also keeps a free-running count of enabled cycles.
module clock_run_controller #(
    parameter int unsigned COUNT_WIDTH = 32,
    parameter int unsigned STEP_WIDTH  = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic                   i_step_req,
    input  logic [STEP_WIDTH-1:0]  i_step_cycles,
    input  logic                   i_halt,
    output logic                   o_clk_enable,
    output logic                   o_done,
    output logic                   o_halted,
    output logic [STEP_WIDTH-1:0]  o_step_remaining,
    output logic [COUNT_WIDTH-1:0] o_cycle_count
);

    typedef enum logic [1:0] {StIdle, StRun, StStep, StHalted} state_e;

    state_e                 r_state;
    state_e                 w_state_d;
    logic [STEP_WIDTH-1:0]  r_remaining;
    logic [STEP_WIDTH-1:0]  w_remaining_d;
    logic                   w_done_d;
    logic                   r_done;
    logic                   r_clk_enable;
    logic                   r_halted;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   w_step_ok;

    assign w_step_ok = i_step_req && (i_step_cycles != '0);

    always_comb begin
        w_state_d     = r_state;
        w_remaining_d = r_remaining;
        w_done_d      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_d = StRun;
                end else if (w_step_ok) begin
                    w_state_d     = StStep;
                    w_remaining_d = i_step_cycles;
                end
            end
            StRun: begin
                if (i_halt) begin
                    w_state_d = StHalted;
                    w_done_d  = 1'b1;
                end else if (i_stop) begin
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
                end
            end
            StStep: begin
                if (i_halt) begin
                    w_state_d     = StHalted;
                    w_done_d      = 1'b1;
                    w_remaining_d = '0;
                end else if (i_stop || (r_remaining == STEP_WIDTH'(1))) begin
                    w_state_d     = StIdle;
                    w_done_d      = 1'b1;
                    w_remaining_d = '0;
                end else begin
                    w_remaining_d = r_remaining - STEP_WIDTH'(1);
                end
            end
            StHalted: begin
                // A held halt masks every request, including stop.
                if (!i_halt) begin
                    if (i_start) begin
                        w_state_d = StRun;
                    end else if (w_step_ok) begin
                        w_state_d     = StStep;
                        w_remaining_d = i_step_cycles;
                    end else if (i_stop) begin
                        w_state_d = StIdle;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_remaining  <= '0;
            r_done       <= 1'b0;
            r_clk_enable <= 1'b0;
            r_halted     <= 1'b0;
            r_count      <= '0;
        end else begin
            r_state      <= w_state_d;
            r_remaining  <= w_remaining_d;
            r_done       <= w_done_d;
            r_clk_enable <= (w_state_d == StRun) || (w_state_d == StStep);
            r_halted     <= (w_state_d == StHalted);
            if (r_clk_enable) begin
                r_count <= r_count + COUNT_WIDTH'(1);
            end
        end
    end

    assign o_clk_enable     = r_clk_enable;
    assign o_done           = r_done;
    assign o_halted         = r_halted;
    assign o_step_remaining = r_remaining;
    assign o_cycle_count    = r_count;

endmodule

// File: doc/clock_run_controller.md
# clock_run_controller

Synchronous run/halt/single-step controller that produces the `enable` input for the processor's clock generator. Sits directly upstream of the clock generator. It accepts run, stop and step requests from the bench or debug front end, and freezes the processor clock when the processor signals halt. It also keeps a free-running count of enabled cycles for performance and debug readout.

## Interface
- `COUNT_WIDTH`, 32, width of the enabled-cycle counter
- `STEP_WIDTH`, 16, width of the step-length request and the remaining-step counter

- `clk`  in  1  free-running reference clock; all state updates on its rising edge
- `reset`  in  1  reset; asynchronous and active-high
- `start`  in  1  request continuous run; sampled per cycle
- `stop`  in  1  request stop of a run or step burst
- `step_req`  in  1  request a burst of `step_cycles` enabled cycles
- `step_cycles`  in  STEP_WIDTH  burst length; sampled only on the edge that accepts `step_req`
- `halt`  in  1  level from processor (e.g. exit syscall); halts the clock
- `clk_enable`  out  1  drives the clock generator's `enable`; registered
- `done`  out  1  one-cycle pulse when a run or burst ends
- `halted`  out  1  high while in HALTED
- `step_remaining`  out  STEP_WIDTH  enabled cycles left in the current burst
- `cycle_count`  out  COUNT_WIDTH  number of edges sampled with `clk_enable`=1

## Operation
- States: IDLE, RUN, STEP, HALTED. Reset → IDLE.
- Reset values: `clk_enable`=0, `done`=0, `halted`=0, `step_remaining`=0, `cycle_count`=0.
- `clk_enable` = 1 exactly when state ∈ {RUN, STEP}.
- `halted` = 1 exactly when state = HALTED.

Transitions are evaluated per edge; the first matching rule wins.
- IDLE:
  - `start` → RUN.
  - Else `step_req` with `step_cycles`≠0 → STEP, loading `step_remaining`=`step_cycles`.
  - `step_req` with `step_cycles`=0 → ignored (no state change, no `done`).
  - `stop` and `halt` → ignored.
- RUN:
  - `halt` → HALTED with `done`.
  - Else `stop` → IDLE with `done`.
  - `start` and `step_req` → ignored.
- STEP:
  - `halt` → HALTED with `done`, `step_remaining` cleared.
  - Else `stop` → IDLE with `done`, `step_remaining` cleared.
  - Else if `step_remaining`=1 → IDLE with `done`, `step_remaining`=0.
  - Else `step_remaining` decrements.
  - `start` and `step_req` → ignored.
- HALTED:
  - While `halt`=1, all requests are ignored.
  - With `halt`=0, `start` → RUN, or else `step_req` → STEP, using the same rules as IDLE.
  - `stop` → IDLE.
- `cycle_count` increments by 1 on every edge where state ∈ {RUN, STEP}. It wraps modulo 2^COUNT_WIDTH with no saturation and no flag. It is cleared only by reset.

## Timing
- Request latency is 1 edge. If `start` is sampled at edge N, `clk_enable` is high after edge N.
- An accepted burst of K cycles holds `clk_enable` high for exactly K clock periods. `cycle_count` advances by exactly K.
- `done` is registered. It is high during the single cycle following the edge that leaves RUN/STEP, and it coincides with the first cycle of `clk_enable`=0.
- `halt` is sampled synchronously. Any enabled cycle in progress when `halt` rises completes, and `clk_enable` falls after the next edge.
- Asserting `reset` mid-run forces IDLE and zeroes all outputs immediately, with no clock needed. No `done` is produced.
- Inputs are assumed synchronous to `clk`. The block contains no synchronizers.

## Test plan
- Reset, then pulse `start` at edge 2 and `stop` at edge 12 → `clk_enable` high for 10 cycles, `cycle_count`=10, one `done` pulse in the cycle after edge 12.
- In IDLE, `step_req` with `step_cycles`=3 → `clk_enable` high for exactly 3 cycles. `step_remaining` reads 3, 2, 1, then 0. `done` pulses once. `cycle_count`=3.
- `step_req` with `step_cycles`=0 → no state change, `clk_enable` stays 0, no `done`. Simultaneous `start`+`step_req` with `step_cycles`=5 → RUN, and `step_remaining` stays 0.
- RUN, then assert `halt` together with `stop` → HALTED with `halted`=1 and one `done`. `start` while `halt`=1 is ignored. Drop `halt`, then pulse `start` → RUN resumes and `cycle_count` continues from its previous value.
- Run with COUNT_WIDTH=4 for 18 enabled cycles → `cycle_count`=2, confirming wrap.
- Assert `reset` asynchronously mid-STEP with `step_remaining`=7 → all outputs 0 before the next `clk` edge, and no `done`.
